// File: rtl/fp_pack.sv
// fp_pack: multi-cycle IEEE-754 binary32 result packer.
//
// Takes an unnormalized sign/exponent/mantissa triple (or a special-case flag) from the
// arithmetic core, normalizes one bit per cycle, rounds to nearest-even and emits a packed
// float together with a one-cycle done pulse.
//
// Ports:
//   clk        in   1   clock, rising edge
//   rst        in   1   asynchronous active-low reset
//   en         in   1   start strobe, sampled only while busy is low
//   flag       in   2   00 normal, 01 zero, 10 infinity, 11 NaN
//   sign       in   1   result sign
//   exp_in     in  10   signed two's-complement biased exponent
//   mant_in    in  28   value = mant_in / 2^26; [27] 2's place, [26] hidden, [25:3] fraction,
//                       [2] guard, [1] round, [0] sticky
//   result     out 32   packed float, held until the next done
//   done       out  1   one-cycle pulse, result valid
//   busy       out  1   operation in progress
//   overflow   out  1   result rounded to infinity (updated with result)
//   underflow  out  1   nonzero input gave a subnormal or zero (updated with result)
module fp_pack (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [1:0]  flag,
  input  logic        sign,
  input  logic [9:0]  exp_in,
  input  logic [27:0] mant_in,
  output logic [31:0] result,
  output logic        done,
  output logic        busy,
  output logic        overflow,
  output logic        underflow
);

  typedef enum logic [1:0] {StIdle, StNorm, StRound} state_e;

  localparam logic [1:0] FlagNormal = 2'b00;
  localparam logic [1:0] FlagZero   = 2'b01;
  localparam logic [1:0] FlagInf    = 2'b10;
  localparam logic [1:0] FlagNan    = 2'b11;

  // Internal exponent is two bits wider than exp_in so the +1 from a 2's-place shift and
  // the +1 from a rounding carry can never wrap.
  localparam logic signed [11:0] ExpFlushLimit = -12'sd24;
  localparam logic signed [11:0] ExpZero       = 12'sd0;
  localparam logic signed [11:0] ExpOne        = 12'sd1;
  localparam logic signed [11:0] ExpMax        = 12'sd255;

  localparam logic [31:0] QuietNan = 32'h7FC0_0000;

  state_e             state_q, state_d;
  logic               sign_q, sign_d;
  logic [1:0]         flag_q, flag_d;
  logic signed [11:0] exp_q, exp_d;
  logic [27:0]        mant_q, mant_d;
  logic [31:0]        result_q, result_d;
  logic               done_q, done_d;
  logic               ovf_q, ovf_d;
  logic               unf_q, unf_d;

  // Shift helpers; the right shift folds the dropped bit into sticky.
  logic [27:0] mant_shr;
  logic [27:0] mant_shl;

  // Rounding path, only consumed in StRound.
  logic               round_up;
  logic [24:0]        sum_hi;
  logic               carry;
  logic               hidden_rnd;
  logic [22:0]        frac_rnd;
  logic signed [11:0] exp_rnd;
  logic [7:0]         exp_field;
  logic               rnd_ovf;

  assign mant_shr = {1'b0, mant_q[27:2], mant_q[1] | mant_q[0]};
  assign mant_shl = {mant_q[26:0], 1'b0};

  // Round-to-nearest-even on guard/round/sticky, incrementing at the fraction LSB.
  assign round_up = mant_q[2] & (mant_q[1] | mant_q[0] | mant_q[3]);
  assign sum_hi   = mant_q[27:3] + {24'd0, round_up};
  assign carry    = sum_hi[24];

  // A carry out of the hidden bit renormalizes by one; the fraction is then all zeros.
  always_comb begin
    hidden_rnd = sum_hi[23];
    frac_rnd   = sum_hi[22:0];
    exp_rnd    = exp_q;
    if (carry) begin
      hidden_rnd = sum_hi[24];
      frac_rnd   = sum_hi[23:1];
      exp_rnd    = exp_q + 12'sd1;
    end
  end

  assign rnd_ovf   = (exp_rnd >= ExpMax);
  assign exp_field = hidden_rnd ? exp_rnd[7:0] : 8'd0;

  always_comb begin
    state_d  = state_q;
    sign_d   = sign_q;
    flag_d   = flag_q;
    exp_d    = exp_q;
    mant_d   = mant_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    done_d   = 1'b0;

    case (state_q)
      StIdle: begin
        if (en) begin
          sign_d  = sign;
          flag_d  = flag;
          exp_d   = {{2{exp_in[9]}}, exp_in};
          mant_d  = mant_in;
          state_d = StNorm;
        end
      end

      StNorm: begin
        if (flag_q != FlagNormal) begin
          unique case (flag_q)
            FlagZero:   result_d = {sign_q, 31'd0};
            FlagInf:    result_d = {sign_q, 8'hFF, 23'd0};
            FlagNan:    result_d = QuietNan;
            FlagNormal: result_d = {sign_q, 31'd0};
          endcase
          ovf_d   = 1'b0;
          unf_d   = 1'b0;
          done_d  = 1'b1;
          state_d = StIdle;
        end else if (mant_q == 28'd0) begin
          result_d = {sign_q, 31'd0};
          ovf_d    = 1'b0;
          unf_d    = 1'b0;
          done_d   = 1'b1;
          state_d  = StIdle;
        end else if (exp_q < ExpFlushLimit) begin
          // Too small to reach even half of the smallest subnormal: flush to zero.
          result_d = {sign_q, 31'd0};
          ovf_d    = 1'b0;
          unf_d    = 1'b1;
          done_d   = 1'b1;
          state_d  = StIdle;
        end else if (mant_q[27] || (exp_q <= ExpZero)) begin
          // Either a 2's-place bit or a denormalizing shift toward exponent 1.
          mant_d = mant_shr;
          exp_d  = exp_q + 12'sd1;
        end else if (!mant_q[26] && (exp_q > ExpOne)) begin
          mant_d = mant_shl;
          exp_d  = exp_q - 12'sd1;
        end else begin
          // Normalized, or parked at exponent 1 as a subnormal.
          state_d = StRound;
        end
      end

      StRound: begin
        if (rnd_ovf) begin
          result_d = {sign_q, 8'hFF, 23'd0};
          ovf_d    = 1'b1;
          unf_d    = 1'b0;
        end else begin
          result_d = {sign_q, exp_field, frac_rnd};
          ovf_d    = 1'b0;
          unf_d    = (exp_field == 8'd0);
        end
        done_d  = 1'b1;
        state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      sign_q   <= 1'b0;
      flag_q   <= 2'b00;
      exp_q    <= 12'sd0;
      mant_q   <= 28'd0;
      result_q <= 32'd0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sign_q   <= sign_d;
      flag_q   <= flag_d;
      exp_q    <= exp_d;
      mant_q   <= mant_d;
      result_q <= result_d;
      done_q   <= done_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  assign result    = result_q;
  assign done      = done_q;
  assign busy      = (state_q != StIdle);
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule

// File: doc/fp_pack.md
# fp_pack

Multi-cycle IEEE-754 single-precision result packer for the FPU datapath. It is the output-side counterpart of the operand classifier `judge`, which splits inputs into special-case flags and hidden bits. `fp_pack` takes an unnormalized sign/exponent/mantissa triple plus a special-case flag from the arithmetic core. It normalizes one bit per cycle, rounds to nearest-even, handles overflow and subnormal results, and emits a packed 32-bit float with a one-cycle `done` pulse.

## Interface
- No parameters; format fixed at binary32 (bias 127).
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `en`  in  1  start strobe; sampled only when `busy`=0.
- `flag`  in  2  special case: 00 normal, 01 zero, 10 infinity, 11 NaN.
- `sign`  in  1  result sign.
- `exp_in`  in  10  signed two's-complement biased exponent.
- `mant_in`  in  28  value = mant_in/2^26. Bit 27 = 2's place, bit 26 = hidden 1, 25:3 fraction, 2 = G, 1 = R, 0 = S (sticky).
- `result`  out  32  packed float; held until next `done`.
- `done`  out  1  one-cycle pulse, result valid.
- `busy`  out  1  operation in progress.
- `overflow`  out  1  result rounded to infinity; valid with `done`, held.
- `underflow`  out  1  nonzero input produced subnormal or flushed zero; valid with `done`, held.

## Operation
- States: IDLE, NORM, ROUND.
- IDLE: when `en`=1, capture all inputs, set `busy`=1, go to NORM.
- NORM, flag≠00: one cycle, then write `result` and return to IDLE.
  - zero → {sign,31'b0}
  - inf → {sign,8'hFF,23'b0}
  - NaN → 32'h7FC00000 (sign ignored)
- NORM, flag=00, one action per cycle, in priority order:
  - mant=0 → result {sign,31'b0}, underflow=0, go to IDLE.
  - exp < -24 → flush {sign,31'b0}, underflow=1, go to IDLE.
  - mant[27]=1 → shift right 1 (bit0 |= shifted-out bit), exp+1.
  - exp ≤ 0 → shift right 1 with sticky, exp+1.
  - mant[26]=0 and exp>1 → shift left 1, exp-1.
  - otherwise (normalized, or exp=1 subnormal) → go to ROUND.
- ROUND (single cycle):
  - Round-to-nearest-even: up = G & (R | S | mant[3]); add `up` at bit 3.
  - Carry into bit 27 → shift right 1, exp+1.
  - exp ≥ 255 → {sign,8'hFF,0}, overflow=1.
  - Else exp field = mant[26] ? exp[7:0] : 0; fraction = mant[25:3].
  - underflow = (exp field = 0).
  - Write result, go to IDLE.
- Leaving NORM/ROUND with a result: `done`=1 and `busy`=0 in the same cycle. `overflow`/`underflow` update together with `result`.
- `en` while busy: ignored, no queuing.
- Reset (any state, including mid-operation): IDLE, `result`=0, `done`=0, `busy`=0, `overflow`=0, `underflow`=0. The aborted operation produces no `done`.

## Timing
- Capture at edge k; `busy` is high from after k until the result edge.
- Special or zero flag: `done` after edge k+1.
- Normalized input, no carry: NORM k+1, `done` after edge k+2.
- Each extra shift adds one cycle; worst case ≈ 28 cycles.
- `done` high exactly one cycle.
- Back-to-back operation: `en`=1 in the `done` cycle is accepted, since `busy`=0 there.

## Test plan
- sign=0, exp=127, mant=28'h4000000 → 32'h3F800000 after edge k+2; overflow=0, underflow=0.
- exp=127, mant=28'h8000000 → 32'h40000000 after edge k+3; exp=130, mant=28'h0800000 → 32'h3F800000 after edge k+5.
- RNE: exp=127, mant=28'h4000004 → 32'h3F800000 (tie, even); mant=28'h400000C → 32'h3F800002.
- Overflow: exp=254, mant=28'h7FFFFFC → 32'h7F800000, overflow=1. Subnormal: exp=0, mant=28'h4000000 → 32'h00400000, underflow=1. Flush: exp=-30 → 32'h00000000, underflow=1.
- Specials: flag=11 → 32'h7FC00000 after edge k+1; flag=10, sign=1 → 32'hFF800000; flag=01, sign=1 → 32'h80000000.
- Assert `rst`=0 during NORM of a left-shift case → all outputs 0 immediately, no `done`. After release, a new `en` completes normally. `en` pulses while `busy` are ignored.
